imm_ext_pipe: RTL and testbench

//  Parametrised immediate-extension stage for the 16-bit datapath, replacing the fixed 9->16 sign extender.

---
 rtl/imm_ext_pkg.sv | 9 +
 rtl/imm_ext_comb.sv | 53 +++++
 rtl/imm_ext_pipe.sv | 113 +++++++++++
 tb/tb_imm_ext_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared mode encodings for the immediate-extension stage.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SEXT     = 2'b00;
    localparam logic [1:0] MODE_ZEXT     = 2'b01;
    localparam logic [1:0] MODE_UPPER    = 2'b10;
    localparam logic [1:0] MODE_SEXT_SHL = 2'b11;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate widening: imm/mode/shamt -> extended data plus truncation flag.
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W    = 9,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHAMT_W = 2
) (
    input  logic [IN_W-1:0]    imm_i,
    input  logic [1:0]         mode_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [OUT_W-1:0]   data_o,
    output logic               trunc_o
);

    localparam int unsigned MaxSh = (1 << SHAMT_W) - 1;
    localparam int unsigned WideW = OUT_W + MaxSh;

    logic [WideW-1:0] sext_w;
    logic [WideW-1:0] zext_w;
    logic [WideW-1:0] shl_w;

    always_comb begin
        sext_w = '0;
        zext_w = '0;
        for (int i = 0; i < int'(WideW); i++) begin
            if (i < int'(IN_W)) begin
                sext_w[i] = imm_i[i];
                zext_w[i] = imm_i[i];
            end else begin
                sext_w[i] = imm_i[IN_W-1];
            end
        end
        // Sign extension reaches past OUT_W so the dropped bits can be inspected after shifting.
        shl_w = sext_w << shamt_i;
    end

    always_comb begin
        data_o  = '0;
        trunc_o = 1'b0;
        case (mode_i)
            MODE_SEXT:  data_o = sext_w[OUT_W-1:0];
            MODE_ZEXT:  data_o = zext_w[OUT_W-1:0];
            MODE_UPPER: data_o = zext_w[OUT_W-1:0] << (OUT_W - IN_W);
            default: begin
                data_o  = shl_w[OUT_W-1:0];
                trunc_o = (shl_w[WideW-1:OUT_W] != {MaxSh{shl_w[OUT_W-1]}}) ||
                          (shl_w[OUT_W-1] != imm_i[IN_W-1]);
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage: combinational widening registered behind a 2-entry skid buffer.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W    = 9,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHAMT_W = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_imm,
    input  logic [1:0]         in_mode,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_trunc,
    output logic [TAG_W-1:0]   out_tag
);

    if (IN_W > OUT_W || IN_W < 2) begin : g_bad_width
        $error("imm_ext_pipe: IN_W must be in 2..OUT_W");
    end

    logic [OUT_W-1:0] new_data;
    logic             new_trunc;

    imm_ext_comb #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHAMT_W (SHAMT_W)
    ) u_comb (
        .imm_i   (in_imm),
        .mode_i  (in_mode),
        .shamt_i (in_shamt),
        .data_o  (new_data),
        .trunc_o (new_trunc)
    );

    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [OUT_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic             main_trunc_q, main_trunc_d, skid_trunc_q, skid_trunc_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic             accept, pop;

    assign accept = in_valid & ~skid_v_q;
    assign pop    = main_v_q & out_ready;

    always_comb begin
        main_v_d     = main_v_q;
        main_data_d  = main_data_q;
        main_trunc_d = main_trunc_q;
        main_tag_d   = main_tag_q;
        skid_v_d     = skid_v_q;
        skid_data_d  = skid_data_q;
        skid_trunc_d = skid_trunc_q;
        skid_tag_d   = skid_tag_q;
        if (!skid_v_q) begin
            if (accept && (!main_v_q || pop)) begin
                main_v_d     = 1'b1;
                main_data_d  = new_data;
                main_trunc_d = new_trunc;
                main_tag_d   = in_tag;
            end else if (accept) begin
                skid_v_d     = 1'b1;
                skid_data_d  = new_data;
                skid_trunc_d = new_trunc;
                skid_tag_d   = in_tag;
            end else if (pop) begin
                main_v_d = 1'b0;
            end
        end else if (pop) begin
            // Skid refills main directly, so main stays valid and order is preserved.
            skid_v_d     = 1'b0;
            main_data_d  = skid_data_q;
            main_trunc_d = skid_trunc_q;
            main_tag_d   = skid_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_q     <= 1'b0;
            main_data_q  <= '0;
            main_trunc_q <= 1'b0;
            main_tag_q   <= '0;
            skid_v_q     <= 1'b0;
            skid_data_q  <= '0;
            skid_trunc_q <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            main_v_q     <= main_v_d;
            main_data_q  <= main_data_d;
            main_trunc_q <= main_trunc_d;
            main_tag_q   <= main_tag_d;
            skid_v_q     <= skid_v_d;
            skid_data_q  <= skid_data_d;
            skid_trunc_q <= skid_trunc_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_trunc = main_trunc_q;
    assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and scoreboarded checks for imm_ext_pipe, default and full-width configurations.
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_trunc;
    logic [8:0]  in_imm;
    logic [1:0]  in_mode, in_shamt;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_data;

    logic        b_in_ready, b_out_valid, b_out_trunc;
    logic [15:0] b_in_imm, b_out_data;
    logic [1:0]  b_in_mode;
    logic [3:0]  b_out_tag;

    int checks = 0;
    int failures = 0;

    imm_ext_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_trunc (out_trunc),
        .out_tag   (out_tag)
    );

    imm_ext_pipe #(
        .IN_W  (16),
        .OUT_W (16)
    ) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (1'b1),
        .in_ready  (b_in_ready),
        .in_imm    (b_in_imm),
        .in_mode   (b_in_mode),
        .in_shamt  (2'd1),
        .in_tag    (4'h9),
        .out_valid (b_out_valid),
        .out_ready (1'b1),
        .out_data  (b_out_data),
        .out_trunc (b_out_trunc),
        .out_tag   (b_out_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [8:0] imm, input logic [1:0] sh,
                        input logic [3:0] tag);
        in_valid = 1'b1;
        in_mode  = m;
        in_imm   = imm;
        in_shamt = sh;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
    endtask

    // Independent arithmetic model for the default 9->16 configuration: {trunc, data}.
    function automatic logic [16:0] ref_ext(input logic [1:0] m, input logic [8:0] imm,
                                            input logic [1:0] sh);
        int          s;
        int          p;
        logic [15:0] o;
        logic        t;
        s = imm[8] ? int'(imm) - 512 : int'(imm);
        case (m)
            2'b00:   return {1'b0, 16'(s)};
            2'b01:   return {1'b0, 7'b0, imm};
            2'b10:   return {1'b0, imm, 7'b0};
            default: begin
                p = s * (1 << sh);
                o = 16'(p);
                t = (p != int'($signed(o))) || (o[15] != imm[8]);
                return {t, o};
            end
        endcase
    endfunction

    logic [20:0] sb[$];
    logic [16:0] r;
    logic        acc, pp;
    int          drain;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = 2'b00;
        in_shamt  = 2'd0;
        in_tag    = '0;
        out_ready = 1'b1;
        b_in_imm  = 16'h4000;
        b_in_mode = 2'b11;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_trunc", 32'(out_trunc), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;

        send(2'b00, 9'b111100000, 2'd0, 4'h1);
        check("sext_valid", 32'(out_valid), 32'd1);
        check("sext_data", 32'(out_data), 32'h0000FFE0);
        check("sext_trunc", 32'(out_trunc), 32'd0);
        check("sext_tag", 32'(out_tag), 32'h1);
        send(2'b01, 9'h1E0, 2'd0, 4'h2);
        check("zext_data", 32'(out_data), 32'h000001E0);
        send(2'b10, 9'h155, 2'd0, 4'h3);
        check("upper_data", 32'(out_data), 32'h0000AA80);
        send(2'b11, 9'h1FF, 2'd2, 4'h4);
        check("shl_data", 32'(out_data), 32'h0000FFFC);
        check("shl_trunc", 32'(out_trunc), 32'd0);
        send(2'b11, 9'h07F, 2'd3, 4'h5);
        check("shl_ovf_data", 32'(out_data), 32'h000003F8);
        check("shl_ovf_trunc", 32'(out_trunc), 32'd0);
        send(2'b11, 9'h0C0, 2'd3, 4'h6);
        check("shl_sign_trunc", 32'(out_trunc), 32'd0);
        check("shl_sign_data", 32'(out_data), 32'h00000600);

        // Full-width instance: inputs were stable since reset release.
        check("w_shl_data", 32'(b_out_data), 32'h00008000);
        check("w_shl_trunc", 32'(b_out_trunc), 32'd1);
        b_in_mode = 2'b00;
        tick();
        check("w_sext_data", 32'(b_out_data), 32'h00004000);
        check("w_sext_trunc", 32'(b_out_trunc), 32'd0);
        b_in_mode = 2'b10;
        tick();
        check("w_upper_data", 32'(b_out_data), 32'h00004000);
        tick();

        // Back-pressure: third item must be refused until the stall clears.
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_shamt  = 2'd0;
        in_imm    = 9'h011;
        in_tag    = 4'h1;
        tick();
        check("bp_ready1", 32'(in_ready), 32'd1);
        in_imm = 9'h022;
        in_tag = 4'h2;
        tick();
        check("bp_ready2", 32'(in_ready), 32'd0);
        in_imm = 9'h033;
        in_tag = 4'h3;
        tick();
        check("bp_hold_tag", 32'(out_tag), 32'h1);
        tick();
        check("bp_hold_data", 32'(out_data), 32'h00000011);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_drain2_tag", 32'(out_tag), 32'h2);
        check("bp_drain2_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_drain3_tag", 32'(out_tag), 32'h3);
        check("bp_drain3_data", 32'(out_data), 32'h00000033);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset with both entries occupied.
        out_ready = 1'b0;
        send(2'b00, 9'h004, 2'd0, 4'h4);
        send(2'b00, 9'h005, 2'd0, 4'h5);
        check("full_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("frst_valid", 32'(out_valid), 32'd0);
        check("frst_ready", 32'(in_ready), 32'd1);
        check("frst_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        send(2'b00, 9'h006, 2'd0, 4'h6);
        check("frst_new_tag", 32'(out_tag), 32'h6);
        check("frst_new_data", 32'(out_data), 32'h00000006);
        tick();
        check("frst_alone", 32'(out_valid), 32'd0);

        // Streaming with random back-pressure against the model.
        for (int c = 0; c < 200; c++) begin
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            in_mode   = 2'($urandom);
            in_imm    = 9'($urandom);
            in_shamt  = 2'($urandom);
            in_tag    = 4'($urandom);
            acc = in_valid & in_ready;
            pp  = out_valid & out_ready;
            if (pp) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    check("sb_item", {11'd0, out_tag, out_trunc, out_data}, {11'd0, sb[0]});
                    void'(sb.pop_front());
                end
            end
            if (acc) begin
                r = ref_ext(in_mode, in_imm, in_shamt);
                sb.push_back({in_tag, r});
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while (out_valid && drain < 10) begin
            if (sb.size() == 0) begin
                check("sb_extra", 32'(out_tag), 32'hFFFF_FFFF);
            end else begin
                check("sb_drain", {11'd0, out_tag, out_trunc, out_data}, {11'd0, sb[0]});
                void'(sb.pop_front());
            end
            tick();
            drain++;
        end
        check("sb_leftover", 32'(sb.size()), 32'd0);
        check("sb_final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
